// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed N-digit LED display scanner with per-digit blank/blink,
// PWM brightness, frame-coherent input latching and an anti-ghosting dead cycle.
module sseg_scan_ctrl #(
   parameter int NDIG         = 8,
   parameter int TICK_DIV     = 12500,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 50,
   parameter bit AN_ACT_LOW   = 1'b1,
   parameter bit SEG_ACT_LOW  = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [NDIG*8-1:0]         din,
   input  logic [NDIG-1:0]           blank,
   input  logic [NDIG-1:0]           blink,
   input  logic [BRIGHT_W-1:0]       bright,
   output logic [NDIG-1:0]           an,
   output logic [7:0]                sseg,
   output logic [$clog2(NDIG)-1:0]   digit_idx,
   output logic                      frame_tick
);

   localparam int IDX_W  = $clog2(NDIG);
   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NDIG - 1);
   localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_FRAMES - 1);
   localparam logic [NDIG-1:0]   AN_OFF     = AN_ACT_LOW  ? {NDIG{1'b1}} : {NDIG{1'b0}};
   localparam logic [7:0]        SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;

   logic [CNT_W-1:0]  pre_cnt;
   logic [IDX_W-1:0]  idx;
   logic [BCNT_W-1:0] blink_cnt;
   logic              blink_ph;

   logic [NDIG*8-1:0] din_sh;
   logic [NDIG-1:0]   blank_sh;
   logic [NDIG-1:0]   blink_sh;

   logic              slot_end;
   logic              frame_start;
   logic              drive;
   logic [NDIG-1:0]   an_hot;
   logic [7:0]        pat;

   assign slot_end    = (pre_cnt == CNT_LAST);
   assign frame_start = (pre_cnt == '0) && (idx == '0);
   assign frame_tick  = slot_end && (idx == IDX_LAST);
   assign digit_idx   = idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt   <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         if (slot_end) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
         if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // NOTE: shadow blank resets to all ones so no digit can light from stale
   // data before the first frame-start latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         din_sh   <= '0;
         blank_sh <= '1;
         blink_sh <= '0;
      end else if (frame_start) begin
         din_sh   <= din;
         blank_sh <= blank;
         blink_sh <= blink;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      an_hot      = '0;
      an_hot[idx] = 1'b1;
      pat         = din_sh[idx*8 +: 8];
      drive       = en
                 && (pre_cnt != '0)
                 && !blank_sh[idx]
                 && !(blink_sh[idx] && blink_ph)
                 && (pre_cnt[BRIGHT_W-1:0] <= bright);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an   <= AN_OFF;
         sseg <= SEG_OFF;
      end else if (drive) begin
         an   <= AN_ACT_LOW  ? ~an_hot : an_hot;
         sseg <= SEG_ACT_LOW ? ~pat    : pat;
      end else begin
         an   <= AN_OFF;
         sseg <= SEG_OFF;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: an 8-digit active-low instance with short
// slots and blink period, plus a 3-digit active-high instance for polarity.
module tb_sseg_scan_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic en;
   always #5 clk = ~clk;

   logic [63:0] din;
   logic [7:0]  blank, blink;
   logic [1:0]  bright;
   logic [7:0]  an, sseg;
   logic [2:0]  digit_idx;
   logic        frame_tick;

   logic [23:0] din_b;
   logic [2:0]  blank_b, blink_b;
   logic [1:0]  bright_b;
   logic [2:0]  an_b;
   logic [7:0]  sseg_b;
   logic [1:0]  idx_b;
   logic        ft_b;

   sseg_scan_ctrl #(
      .NDIG(8), .TICK_DIV(16), .BRIGHT_W(2), .BLINK_FRAMES(2),
      .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .din(din), .blank(blank), .blink(blink),
      .bright(bright), .an(an), .sseg(sseg), .digit_idx(digit_idx), .frame_tick(frame_tick)
   );

   sseg_scan_ctrl #(
      .NDIG(3), .TICK_DIV(16), .BRIGHT_W(2), .BLINK_FRAMES(2),
      .AN_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
   ) dut_b (
      .clk(clk), .reset(reset), .en(en), .din(din_b), .blank(blank_b), .blink(blink_b),
      .bright(bright_b), .an(an_b), .sseg(sseg_b), .digit_idx(idx_b), .frame_tick(ft_b)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Runs one 16-cycle slot of the 8-digit instance; lit_mask bit p says whether
   // the output registered from pre_cnt=p should be lit.
   task automatic check_slot(input int i, input logic [15:0] lit_mask, input logic [7:0] pat);
      logic [7:0] e_an, e_seg;
      for (int j = 1; j <= 16; j++) begin
         tick();
         if (lit_mask[j-1]) begin
            e_an  = ~(8'h01 << i);
            e_seg = ~pat;
         end else begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
         end
         check("an", an, e_an);
         check("sseg", sseg, e_seg);
         check("digit_idx", digit_idx, (j == 16) ? (i + 1) % 8 : i);
         check("frame_tick", frame_tick, (i == 7 && j == 15));
      end
   endtask

   typedef struct {
      logic [1:0]  bright;
      logic [15:0] lit_mask;
   } bright_vec_t;

   bright_vec_t bv[4];

   initial begin
      logic [15:0] mask;
      logic [7:0]  pat;
      logic [2:0]  e_anb;
      logic [7:0]  e_segb;

      bv[0] = '{2'd0, 16'h1110};
      bv[1] = '{2'd1, 16'h3332};
      bv[2] = '{2'd2, 16'h7776};
      bv[3] = '{2'd3, 16'hFFFE};

      reset    = 1'b1;
      en       = 1'b1;
      bright   = 2'd3;
      din      = {8{8'h3F}};
      blank    = 8'h00;
      blink    = 8'h00;
      din_b    = {8'h5B, 8'h06, 8'h3F};
      blank_b  = 3'b000;
      blink_b  = 3'b000;
      bright_b = 2'd3;

      #12;
      check("reset_an", an, 8'hFF);
      check("reset_sseg", sseg, 8'hFF);
      check("reset_idx", digit_idx, 0);
      check("reset_ftick", frame_tick, 0);
      check("reset_an_b", an_b, 0);
      check("reset_sseg_b", sseg_b, 0);
      @(negedge clk);
      reset = 1'b0;

      // frame 0: full brightness, all digits 3F
      for (int i = 0; i < 8; i++) check_slot(i, 16'hFFFE, 8'h3F);

      // frame 1: brightness sweep on slots 0..3
      for (int i = 0; i < 4; i++) begin
         bright = bv[i].bright;
         check_slot(i, bv[i].lit_mask, 8'h3F);
      end
      bright = 2'd3;
      for (int i = 4; i < 8; i++) check_slot(i, 16'hFFFE, 8'h3F);

      // frame 2: change digits 0 and 5 while idx=3; not visible until next frame
      for (int i = 0; i < 3; i++) check_slot(i, 16'hFFFE, 8'h3F);
      din[7:0]   = 8'h06;
      din[47:40] = 8'h06;
      for (int i = 3; i < 8; i++) check_slot(i, 16'hFFFE, 8'h3F);

      // frame 3: new din visible; blank/blink changed mid-frame, not yet visible
      check_slot(0, 16'hFFFE, 8'h06);
      blank = 8'h04;
      blink = 8'h02;
      for (int i = 1; i < 8; i++) check_slot(i, 16'hFFFE, (i == 5) ? 8'h06 : 8'h3F);

      // frames 4..7: digit2 blanked; digit1 lit in 4-5, dark in 6-7
      for (int f = 4; f < 8; f++) begin
         for (int i = 0; i < 8; i++) begin
            pat  = (i == 0 || i == 5) ? 8'h06 : 8'h3F;
            mask = (i == 2 || (i == 1 && f >= 6)) ? 16'h0000 : 16'hFFFE;
            check_slot(i, mask, pat);
         end
      end

      // frame 8: en drop at pre_cnt=7, then reset at pre_cnt=9 of slot 1
      for (int j = 0; j < 7; j++) tick();
      check("pre_en_an", an, 8'hFE);
      check("pre_en_sseg", sseg, 8'hF9);
      en = 1'b0;
      tick();
      check("en_off_an", an, 8'hFF);
      check("en_off_sseg", sseg, 8'hFF);
      check("en_off_idx", digit_idx, 0);
      for (int j = 0; j < 8; j++) tick();
      check("en_off_idx_adv", digit_idx, 1);
      check("en_off_an2", an, 8'hFF);
      en = 1'b1;
      for (int j = 0; j < 9; j++) tick();
      check("blink_on_an", an, 8'hFD);
      check("blink_on_sseg", sseg, 8'hC0);
      check("blink_on_idx", digit_idx, 1);
      #2 reset = 1'b1;
      #1;
      check("midreset_an", an, 8'hFF);
      check("midreset_sseg", sseg, 8'hFF);
      check("midreset_idx", digit_idx, 0);
      check("midreset_ftick", frame_tick, 0);
      check("midreset_an_b", an_b, 0);
      check("midreset_sseg_b", sseg_b, 0);
      @(negedge clk);
      reset = 1'b0;

      // after reset: 3-digit active-high instance scans 001,010,100,001
      for (int s = 0; s < 4; s++) begin
         for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 1) begin
               e_anb  = 3'b000;
               e_segb = 8'h00;
            end else begin
               e_anb  = 3'(1 << (s % 3));
               e_segb = din_b[8*(s % 3) +: 8];
            end
            check("an_b", an_b, e_anb);
            check("sseg_b", sseg_b, e_segb);
            if (s == 0 && j > 1) begin
               check("post_reset_an", an, 8'hFE);
               check("post_reset_sseg", sseg, 8'hF9);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
